// File: rtl/divider_pkg.sv
// Shared definitions for the sequential restoring divider.
//   WIDTH_DEF : default operand/result width
//   state_t   : controller states (IDLE, RUN, DONE)
//   cnt_width : width of the iteration counter for a given operand width
package divider_pkg;

  localparam int unsigned WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  localparam int unsigned CNT_W = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/sub_stage.sv
// Ripple-borrow subtractor built from full-adder cells: o_diff = i_a - i_b,
// computed as i_a + ~i_b + 1.
//   i_a    : minuend
//   i_b    : subtrahend
//   o_diff : difference (modulo 2**WIDTH)
//   o_cout : carry out of the top cell; 1 means no borrow (i_a >= i_b)
module sub_stage #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_bn;

  assign w_bn   = ~i_b;
  assign w_c[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    assign o_diff[gi]  = i_a[gi] ^ w_bn[gi] ^ w_c[gi];
    assign w_c[gi + 1] = (i_a[gi] & w_bn[gi]) | (i_a[gi] & w_c[gi]) | (w_bn[gi] & w_c[gi]);
  end

  assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/seq_divider4.sv
// Sequential restoring divider, one quotient bit per clock, MSB first.
//   clk         : rising-edge clock
//   rst         : asynchronous active-high reset
//   start       : begin a division (accepted in IDLE or DONE only)
//   dividend    : unsigned numerator, sampled with an accepted start
//   divisor     : unsigned denominator, sampled with an accepted start
//   busy        : high while iterations are in progress
//   done        : one-cycle pulse, results valid
//   quotient    : registered quotient (all ones on divide by zero)
//   remainder   : registered remainder (dividend on divide by zero)
//   div_by_zero : registered flag, sampled divisor was zero
module seq_divider4
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned   CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_q;
  logic [CW-1:0]    r_cnt;
  logic             r_zpend;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_remo;
  logic             r_dz;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_rem_nxt;
  logic             w_nb;
  logic             w_unused_bits;

  assign w_accept  = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last    = (r_cnt == LAST);
  assign w_shifted = {r_rem[WIDTH-1:0], r_dvd[WIDTH-1]};

  sub_stage #(.WIDTH(WIDTH + 1)) u_sub (
    .i_a    (w_shifted),
    .i_b    ({1'b0, r_dvs}),
    .o_diff (w_trial),
    .o_cout (w_nb)
  );

  assign w_rem_nxt = w_nb ? w_trial : w_shifted;

  // Partial remainder stays below the divisor, so its top bit is never read;
  // the first quotient bit shifts out of r_q before the final load.
  assign w_unused_bits = r_rem[WIDTH] ^ r_q[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // A zero divisor still passes through RUN for one cycle (r_zpend set, busy
  // masked) so the result appears one edge after the accepting edge.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (r_zpend || w_last) w_next = DONE;
      DONE:    w_next = start ? RUN : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_zpend <= 1'b0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_dz    <= 1'b0;
    end else if (w_accept) begin
      r_dvd   <= dividend;
      r_dvs   <= divisor;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_zpend <= (divisor == '0);
      if (divisor != '0) r_dz <= 1'b0;
    end else if (r_state == RUN) begin
      if (r_zpend) begin
        r_quot  <= '1;
        r_remo  <= r_dvd;
        r_dz    <= 1'b1;
        r_zpend <= 1'b0;
      end else begin
        r_rem <= w_rem_nxt;
        r_dvd <= {r_dvd[WIDTH-2:0], 1'b0};
        r_q   <= {r_q[WIDTH-2:0], w_nb};
        r_cnt <= r_cnt + CW'(1);
        if (w_last) begin
          r_quot <= {r_q[WIDTH-2:0], w_nb};
          r_remo <= w_rem_nxt[WIDTH-1:0];
        end
      end
    end
  end

  assign busy        = (r_state == RUN) && !r_zpend;
  assign done        = (r_state == DONE);
  assign quotient    = r_quot;
  assign remainder   = r_remo;
  assign div_by_zero = r_dz;

endmodule
